// File: rtl/wave_mon_pkg.sv
// -----------------------------------------------------------------------------
// wave_mon_pkg
//   Shared types and helpers for the wave_edge_monitor block.
//   - edge_kind_e : which transition of a monitored bit counts as an edge
//   - fail_code_e : cause recorded for the most recent failure of a channel
//   - mon_state_e : per-channel monitor FSM states
//   - edge_match  : combinational edge classifier for one bit
// -----------------------------------------------------------------------------
package wave_mon_pkg;

  typedef enum logic [1:0] {
    RISE = 2'd0,
    FALL = 2'd1,
    ANY  = 2'd2,
    RSVD = 2'd3
  } edge_kind_e;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    EARLY   = 2'd1,
    TIMEOUT = 2'd2,
    CONFIG  = 2'd3
  } fail_code_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mon_state_e;

  // The reserved kind never matches, so a channel configured with it stays inert.
  function automatic logic edge_match(input logic cur, input logic prev,
                                      input edge_kind_e kind);
    case (kind)
      RISE:    return cur & ~prev;
      FALL:    return ~cur & prev;
      ANY:     return cur ^ prev;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wave_mon_channel.sv
// -----------------------------------------------------------------------------
// wave_mon_channel
//   One edge-to-edge timing check. Arms on a source edge, counts cycles and
//   resolves on a destination edge (pass / early fail) or on reaching the
//   maximum delay (timeout fail). Keeps a sticky fail flag, the last fail code
//   and a saturating fail counter.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   en                channel enable; low forces IDLE without a result
//   clr               clears sticky flag, fail code and counter
//   edge_vld          edge history valid (masks all edges when low)
//   src_cur/src_prev  current / previous sample of the selected source bit
//   src_edge          live source edge kind
//   dst_sel/dst_edge  destination bit index / kind, latched on arm
//   min_dly/max_dly   delay window, latched on arm (max 0 = unbounded)
//   dst_cur/dst_prev  current / previous sample of the latched destination bit
//   dst_sel_q         latched destination index, used by the parent's mux
//   pass/fail         one-cycle result pulses
//   fail_code         last fail cause
//   fail_sticky       set on any fail until cleared
//   fail_cnt          saturating fail count
//   busy              channel is in WAIT
// -----------------------------------------------------------------------------
module wave_mon_channel
  import wave_mon_pkg::*;
#(
  parameter int DLY_W = 8,
  parameter int CNT_W = 16,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             edge_vld,
  input  logic             src_cur,
  input  logic             src_prev,
  input  logic [1:0]       src_edge,
  input  logic [SEL_W-1:0] dst_sel,
  input  logic [1:0]       dst_edge,
  input  logic [DLY_W-1:0] min_dly,
  input  logic [DLY_W-1:0] max_dly,
  input  logic             dst_cur,
  input  logic             dst_prev,
  output logic [SEL_W-1:0] dst_sel_q,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic             fail_sticky,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [DLY_W-1:0] sat_inc_dly(input logic [DLY_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  mon_state_e       state_q, state_d;
  logic [DLY_W-1:0] k_q, k_d, k_inc;
  logic [DLY_W-1:0] min_q, max_q;
  edge_kind_e       dst_kind_q;
  fail_code_e       code_q;

  logic             src_hit, dst_hit, cfg_bad, timeout;
  logic             arm, res_pass, res_fail;
  fail_code_e       res_code;

  assign src_hit = edge_vld & edge_match(src_cur, src_prev, edge_kind_e'(src_edge));
  assign dst_hit = edge_vld & edge_match(dst_cur, dst_prev, dst_kind_q);
  assign cfg_bad = (max_dly != '0) && (min_dly > max_dly);
  // Checks use the post-increment count: first cycle after the trigger is k = 1.
  assign k_inc   = sat_inc_dly(k_q);
  assign timeout = (max_q != '0) && (k_inc == max_q);

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    arm      = 1'b0;
    res_pass = 1'b0;
    res_fail = 1'b0;
    res_code = NONE;
    if (!en) begin
      state_d = IDLE;
      k_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // A destination edge in IDLE is ignored, even alongside a source.
          if (src_hit) begin
            if (cfg_bad) begin
              res_fail = 1'b1;
              res_code = CONFIG;
            end else begin
              arm     = 1'b1;
              state_d = WAIT;
              k_d     = '0;
            end
          end
        end
        WAIT: begin
          k_d = k_inc;
          if (dst_hit) begin
            if (k_inc < min_q) begin
              res_fail = 1'b1;
              res_code = EARLY;
            end else begin
              res_pass = 1'b1;
            end
          end else if (timeout) begin
            res_fail = 1'b1;
            res_code = TIMEOUT;
          end
          // A source edge only matters when the current check resolves;
          // then the channel re-arms straight away with fresh config.
          if (dst_hit || timeout) begin
            k_d = '0;
            if (src_hit && !cfg_bad) begin
              arm = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          k_d     = '0;
        end
      endcase
    end
  end

  // Stage boundary: FSM state, delay counter, result pulses and fail record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      code_q      <= NONE;
      fail_sticky <= 1'b0;
      fail_cnt    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      pass    <= res_pass;
      fail    <= res_fail;
      if (res_fail) begin
        // A fail coincident with clr wins: the record restarts at this fail.
        fail_sticky <= 1'b1;
        code_q      <= res_code;
        fail_cnt    <= clr ? CNT_ONE : sat_inc_cnt(fail_cnt);
      end else if (clr) begin
        fail_sticky <= 1'b0;
        code_q      <= NONE;
        fail_cnt    <= '0;
      end
    end
  end

  // Stage boundary: destination and window config captured at arm time.
  always_ff @(posedge clk) begin
    if (arm) begin
      dst_sel_q  <= dst_sel;
      dst_kind_q <= edge_kind_e'(dst_edge);
      min_q      <= min_dly;
      max_q      <= max_dly;
    end
  end

  assign fail_code = code_q;
  assign busy      = (state_q == WAIT);

endmodule

// File: rtl/wave_edge_monitor.sv
// -----------------------------------------------------------------------------
// wave_edge_monitor
//   Run-time configurable edge-to-edge timing monitor with NUM_CH independent
//   channels over an NUM_SIG-bit signal vector. Holds the one-cycle sample
//   history, selects each channel's source/destination bits and packs the
//   per-channel results onto flat ports.
//
// Ports
//   clk, rst_n                clock, asynchronous active-low reset
//   sig_i        [NUM_SIG]    monitored signals, synchronous to clk
//   chan_en_i    [NUM_CH]     channel enables
//   src_sel_i    [NUM_CH*SEL_W] source bit index per channel
//   dst_sel_i    [NUM_CH*SEL_W] destination bit index per channel
//   src_edge_i   [NUM_CH*2]   source edge kind (rise/fall/any/reserved)
//   dst_edge_i   [NUM_CH*2]   destination edge kind
//   min_dly_i    [NUM_CH*DLY_W] minimum delay in cycles
//   max_dly_i    [NUM_CH*DLY_W] maximum delay in cycles, 0 = unbounded
//   clr_i                     clears sticky flags, fail codes and counters
//   pass_o/fail_o [NUM_CH]    one-cycle result pulses
//   fail_code_o  [NUM_CH*2]   last fail cause per channel
//   fail_sticky_o [NUM_CH]    sticky fail flags
//   fail_cnt_o   [NUM_CH*CNT_W] saturating fail counters
//   busy_o       [NUM_CH]     channel waiting for its destination
// -----------------------------------------------------------------------------
module wave_edge_monitor
  import wave_mon_pkg::*;
#(
  parameter int NUM_SIG = 8,
  parameter int NUM_CH  = 4,
  parameter int DLY_W   = 8,
  parameter int CNT_W   = 16,
  // Derived; leave at its default.
  parameter int SEL_W   = $clog2(NUM_SIG)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_SIG-1:0]      sig_i,
  input  logic [NUM_CH-1:0]       chan_en_i,
  input  logic [NUM_CH*SEL_W-1:0] src_sel_i,
  input  logic [NUM_CH*SEL_W-1:0] dst_sel_i,
  input  logic [NUM_CH*2-1:0]     src_edge_i,
  input  logic [NUM_CH*2-1:0]     dst_edge_i,
  input  logic [NUM_CH*DLY_W-1:0] min_dly_i,
  input  logic [NUM_CH*DLY_W-1:0] max_dly_i,
  input  logic                    clr_i,
  output logic [NUM_CH-1:0]       pass_o,
  output logic [NUM_CH-1:0]       fail_o,
  output logic [NUM_CH*2-1:0]     fail_code_o,
  output logic [NUM_CH-1:0]       fail_sticky_o,
  output logic [NUM_CH*CNT_W-1:0] fail_cnt_o,
  output logic [NUM_CH-1:0]       busy_o
);

  logic [NUM_SIG-1:0] sig_q;
  logic               prev_vld;

  // Stage boundary: previous-sample history. Edges stay masked until the
  // first post-reset sample exists, so nothing fires from the reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q    <= '0;
      prev_vld <= 1'b0;
    end else begin
      sig_q    <= sig_i;
      prev_vld <= 1'b1;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [SEL_W-1:0] src_sel_c;
    logic [SEL_W-1:0] dst_sel_q_c;
    logic             src_cur_c, src_prev_c;
    logic             dst_cur_c, dst_prev_c;

    assign src_sel_c  = src_sel_i[c*SEL_W +: SEL_W];
    assign src_cur_c  = sig_i[src_sel_c];
    assign src_prev_c = sig_q[src_sel_c];
    // The destination follows the index latched at arm, not the live input.
    assign dst_cur_c  = sig_i[dst_sel_q_c];
    assign dst_prev_c = sig_q[dst_sel_q_c];

    wave_mon_channel #(
      .DLY_W (DLY_W),
      .CNT_W (CNT_W),
      .SEL_W (SEL_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (chan_en_i[c]),
      .clr         (clr_i),
      .edge_vld    (prev_vld),
      .src_cur     (src_cur_c),
      .src_prev    (src_prev_c),
      .src_edge    (src_edge_i[c*2 +: 2]),
      .dst_sel     (dst_sel_i[c*SEL_W +: SEL_W]),
      .dst_edge    (dst_edge_i[c*2 +: 2]),
      .min_dly     (min_dly_i[c*DLY_W +: DLY_W]),
      .max_dly     (max_dly_i[c*DLY_W +: DLY_W]),
      .dst_cur     (dst_cur_c),
      .dst_prev    (dst_prev_c),
      .dst_sel_q   (dst_sel_q_c),
      .pass        (pass_o[c]),
      .fail        (fail_o[c]),
      .fail_code   (fail_code_o[c*2 +: 2]),
      .fail_sticky (fail_sticky_o[c]),
      .fail_cnt    (fail_cnt_o[c*CNT_W +: CNT_W]),
      .busy        (busy_o[c])
    );
  end

endmodule

// File: tb/tb_wave_edge_monitor.sv
module tb_wave_edge_monitor;

  localparam int NUM_SIG = 8;
  localparam int NUM_CH  = 4;
  localparam int DLY_W   = 8;
  localparam int CNT_W   = 16;
  localparam int SEL_W   = 3;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_SIG-1:0]      sig_i;
  logic [NUM_CH-1:0]       chan_en_i;
  logic [NUM_CH*SEL_W-1:0] src_sel_i;
  logic [NUM_CH*SEL_W-1:0] dst_sel_i;
  logic [NUM_CH*2-1:0]     src_edge_i;
  logic [NUM_CH*2-1:0]     dst_edge_i;
  logic [NUM_CH*DLY_W-1:0] min_dly_i;
  logic [NUM_CH*DLY_W-1:0] max_dly_i;
  logic                    clr_i;
  logic [NUM_CH-1:0]       pass_o;
  logic [NUM_CH-1:0]       fail_o;
  logic [NUM_CH*2-1:0]     fail_code_o;
  logic [NUM_CH-1:0]       fail_sticky_o;
  logic [NUM_CH*CNT_W-1:0] fail_cnt_o;
  logic [NUM_CH-1:0]       busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  wave_edge_monitor #(
    .NUM_SIG (NUM_SIG),
    .NUM_CH  (NUM_CH),
    .DLY_W   (DLY_W),
    .CNT_W   (CNT_W),
    .SEL_W   (SEL_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sig_i         (sig_i),
    .chan_en_i     (chan_en_i),
    .src_sel_i     (src_sel_i),
    .dst_sel_i     (dst_sel_i),
    .src_edge_i    (src_edge_i),
    .dst_edge_i    (dst_edge_i),
    .min_dly_i     (min_dly_i),
    .max_dly_i     (max_dly_i),
    .clr_i         (clr_i),
    .pass_o        (pass_o),
    .fail_o        (fail_o),
    .fail_code_o   (fail_code_o),
    .fail_sticky_o (fail_sticky_o),
    .fail_cnt_o    (fail_cnt_o),
    .busy_o        (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_cfg0(input logic [SEL_W-1:0] ss, input logic [1:0] se,
                          input logic [SEL_W-1:0] ds, input logic [1:0] de,
                          input logic [DLY_W-1:0] mn, input logic [DLY_W-1:0] mx);
    src_sel_i[SEL_W-1:0]  = ss;
    src_edge_i[1:0]       = se;
    dst_sel_i[SEL_W-1:0]  = ds;
    dst_edge_i[1:0]       = de;
    min_dly_i[DLY_W-1:0]  = mn;
    max_dly_i[DLY_W-1:0]  = mx;
  endtask

  initial begin
    rst_n      = 1'b0;
    sig_i      = '0;
    chan_en_i  = 4'b0001;
    src_sel_i  = '0;
    dst_sel_i  = '0;
    src_edge_i = '0;
    dst_edge_i = '0;
    min_dly_i  = '0;
    max_dly_i  = '0;
    clr_i      = 1'b0;

    // Reset state
    tick_n(2);
    check("rst_pass", pass_o, 0);
    check("rst_fail", fail_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_sticky", fail_sticky_o, 0);
    check("rst_code", fail_code_o, 0);
    check("rst_cnt", fail_cnt_o[CNT_W-1:0], 0);

    // bit0 rise -> bit1 any, window [1,1]
    set_cfg0(3'd0, 2'd0, 3'd1, 2'd2, 8'd1, 8'd1);
    rst_n = 1'b1;
    tick();
    sig_i[0] = 1'b1; tick();              // T0
    check("t1_busy_arm", busy_o[0], 1);
    check("t1_no_pass_yet", pass_o[0], 0);
    sig_i[1] = 1'b1; tick();              // T0+1
    check("t1_pass", pass_o[0], 1);
    check("t1_no_fail", fail_o[0], 0);
    check("t1_busy_done", busy_o[0], 0);
    tick();
    check("t1_pass_one_cycle", pass_o[0], 0);
    sig_i[0] = 1'b0; tick();              // falling bit0 does not arm a RISE source
    check("t1_fall_ignored", busy_o[0], 0);

    // Disabling a waiting channel drops it with no pulse
    sig_i[0] = 1'b1; tick();
    check("en_busy", busy_o[0], 1);
    chan_en_i[0] = 1'b0; tick();
    check("en_off_busy", busy_o[0], 0);
    check("en_off_nopass", pass_o[0] | fail_o[0], 0);
    chan_en_i[0] = 1'b1;
    sig_i[0] = 1'b0; tick();

    // Reserved source kind never arms
    set_cfg0(3'd0, 2'd3, 3'd1, 2'd2, 8'd1, 8'd1);
    sig_i[0] = 1'b1; tick();
    check("rsvd_no_arm", busy_o[0], 0);
    sig_i[0] = 1'b0; tick();

    // bit4 fall -> bit3 any, window [2,2]: early
    set_cfg0(3'd4, 2'd1, 3'd3, 2'd2, 8'd2, 8'd2);
    sig_i[4] = 1'b1; tick();
    check("t2_rise_no_arm", busy_o[0], 0);
    sig_i[4] = 1'b0; tick();              // T0
    check("t2_busy", busy_o[0], 1);
    sig_i[3] = 1'b1; tick();              // T0+1
    check("t2_fail", fail_o[0], 1);
    check("t2_code_early", fail_code_o[1:0], 1);
    check("t2_cnt", fail_cnt_o[CNT_W-1:0], 1);
    check("t2_sticky", fail_sticky_o[0], 1);
    check("t2_idle", busy_o[0], 0);

    // Same config, no destination: timeout at T0+2
    sig_i[4] = 1'b1; tick();
    sig_i[4] = 1'b0; tick();              // T0
    tick();                               // T0+1
    check("t3_wait_nofail", fail_o[0], 0);
    check("t3_wait_busy", busy_o[0], 1);
    tick();                               // T0+2
    check("t3_fail", fail_o[0], 1);
    check("t3_code_timeout", fail_code_o[1:0], 2);
    check("t3_cnt", fail_cnt_o[CNT_W-1:0], 2);

    // Same config, destination exactly at T0+2: pass
    sig_i[4] = 1'b1; tick();
    sig_i[4] = 1'b0; tick();              // T0
    tick();                               // T0+1
    sig_i[3] = 1'b0; tick();              // T0+2
    check("t3b_pass", pass_o[0], 1);
    check("t3b_nofail", fail_o[0], 0);
    check("t3b_cnt_kept", fail_cnt_o[CNT_W-1:0], 2);

    // Unbounded window, min 3: destination at T0+200
    set_cfg0(3'd4, 2'd1, 3'd3, 2'd2, 8'd3, 8'd0);
    sig_i[4] = 1'b1; tick();
    sig_i[4] = 1'b0; tick();              // T0
    tick_n(199);
    check("t4_busy_199", busy_o[0], 1);
    check("t4_nopass_199", pass_o[0] | fail_o[0], 0);
    sig_i[3] = 1'b1; tick();              // T0+200
    check("t4_pass_200", pass_o[0], 1);

    // Destination at T0+300: counter saturated, still a pass
    sig_i[4] = 1'b1; tick();
    sig_i[4] = 1'b0; tick();              // T0
    tick_n(299);
    check("t4_busy_299", busy_o[0], 1);
    sig_i[3] = 1'b0; tick();              // T0+300
    check("t4_pass_300", pass_o[0], 1);
    check("t4_nofail_300", fail_o[0], 0);

    // min 5 > max 2: config fail, no arm
    set_cfg0(3'd4, 2'd1, 3'd3, 2'd2, 8'd5, 8'd2);
    sig_i[4] = 1'b1; tick();
    sig_i[4] = 1'b0; tick();              // T0
    check("t5_fail", fail_o[0], 1);
    check("t5_code_config", fail_code_o[1:0], 3);
    check("t5_busy", busy_o[0], 0);
    check("t5_cnt", fail_cnt_o[CNT_W-1:0], 3);
    sig_i[4] = 1'b1; tick();
    sig_i[4] = 1'b0; clr_i = 1'b1; tick();
    check("t5_clr_fail", fail_o[0], 1);
    check("t5_clr_cnt", fail_cnt_o[CNT_W-1:0], 1);
    check("t5_clr_sticky", fail_sticky_o[0], 1);
    check("t5_clr_code", fail_code_o[1:0], 3);
    tick();                               // clr alone
    clr_i = 1'b0;
    check("t5_clr_only_cnt", fail_cnt_o[CNT_W-1:0], 0);
    check("t5_clr_only_sticky", fail_sticky_o[0], 0);
    check("t5_clr_only_code", fail_code_o[1:0], 0);

    // Reset mid-WAIT; no rearm from the stale level afterwards
    set_cfg0(3'd0, 2'd0, 3'd1, 2'd2, 8'd1, 8'd0);
    sig_i[0] = 1'b1; tick();
    check("t6_busy", busy_o[0], 1);
    rst_n = 1'b0; #1;
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_pulse", pass_o | fail_o, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_no_stale_arm", busy_o[0], 0);
    tick();
    check("t6_still_idle", busy_o[0], 0);
    check("t6_no_pulse", pass_o | fail_o, 0);

    // Resolution with a coincident source edge re-arms
    sig_i[0] = 1'b0; tick();
    sig_i[0] = 1'b1; tick();              // arm
    check("t7_busy", busy_o[0], 1);
    sig_i[0] = 1'b0; tick();              // fall is not a source edge
    sig_i[0] = 1'b1; sig_i[1] = ~sig_i[1]; tick();
    check("t7_pass", pass_o[0], 1);
    check("t7_rearmed", busy_o[0], 1);
    sig_i[1] = ~sig_i[1]; tick();
    check("t7_pass2", pass_o[0], 1);
    check("t7_idle", busy_o[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
